// File: rtl/led_anim_ctrl_if.sv
// led_anim_ctrl_if: bundle between the animation sequencer and its surroundings.
//   sw        [1:0]  speed switches (00 step mode, 01 slow, 10 med, 11 fast)
//   btn_step         single-step button, debounced, active-high
//   frame_idx [4:0]  current frame number to the frame ROM
//   frame_stb        one-cycle pulse when frame_idx takes a new value
//   running          high while the sequencer free-runs
// master = the board side driving switches/button; slave = the sequencer.
`timescale 1ns/1ps
interface led_anim_ctrl_if;
    logic [1:0] sw;
    logic       btn_step;
    logic [4:0] frame_idx;
    logic       frame_stb;
    logic       running;

    modport master (output sw, btn_step, input frame_idx, frame_stb, running);
    modport slave  (input sw, btn_step, output frame_idx, frame_stb, running);
endinterface

// File: rtl/led_anim_ctrl.sv
// led_anim_ctrl: frame sequencer for the 16-LED animation datapath.
// Synchronises the speed switches and step button, runs a prescaler that
// advances the frame index at the selected rate, or single-steps in stop mode.
// Ports:
//   clk  board clock, all logic on posedge
//   rst  synchronous active-high reset
//   bus  led_anim_ctrl_if.slave (sw, btn_step in; frame_idx, frame_stb, running out)
`timescale 1ns/1ps
module led_anim_ctrl #(
    parameter int PERIOD_SLOW = 100000000,
    parameter int PERIOD_MED  = 50000000,
    parameter int PERIOD_FAST = 20000000,
    parameter int CNT_W       = 27,
    parameter int NFRAMES     = 32
) (
    input  logic            clk,
    input  logic            rst,
    led_anim_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sw_s1_q, sw_s_q;
    logic             btn_s1_q, btn_s_q, btn_s_d_q;
    logic [1:0]       mode_cur_q, mode_cur_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [4:0]       frame_q, frame_d;
    logic             stb_q, stb_d;
    logic [1:0]       mode;
    logic             step_evt;

    function automatic logic [CNT_W-1:0] period_m1(input logic [1:0] m);
        case (m)
            2'b01:   return CNT_W'(PERIOD_SLOW - 1);
            2'b10:   return CNT_W'(PERIOD_MED - 1);
            default: return CNT_W'(PERIOD_FAST - 1);
        endcase
    endfunction

    function automatic logic [4:0] frame_next(input logic [4:0] f);
        return (f == 5'(NFRAMES - 1)) ? 5'd0 : f + 5'd1;
    endfunction

    assign mode     = sw_s_q;
    assign step_evt = btn_s_q & ~btn_s_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q    <= 2'b00;
            sw_s_q     <= 2'b00;
            btn_s1_q   <= 1'b0;
            btn_s_q    <= 1'b0;
            btn_s_d_q  <= 1'b0;
            state_q    <= IDLE;
            mode_cur_q <= 2'b00;
            presc_q    <= '0;
            frame_q    <= 5'd0;
            stb_q      <= 1'b0;
        end else begin
            sw_s1_q    <= bus.sw;
            sw_s_q     <= sw_s1_q;
            btn_s1_q   <= bus.btn_step;
            btn_s_q    <= btn_s1_q;
            btn_s_d_q  <= btn_s_q;
            state_q    <= state_d;
            mode_cur_q <= mode_cur_d;
            presc_q    <= presc_d;
            frame_q    <= frame_d;
            stb_q      <= stb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_cur_d = mode_cur_q;
        presc_d    = presc_q;
        frame_d    = frame_q;
        stb_d      = 1'b0;
        case (state_q)
            IDLE: begin
                presc_d = '0;
                // Entering RUN takes priority; a step in the same cycle is dropped.
                if (mode != 2'b00) begin
                    state_d    = RUN;
                    mode_cur_d = mode;
                    presc_d    = period_m1(mode);
                end else if (step_evt) begin
                    frame_d = frame_next(frame_q);
                    stb_d   = 1'b1;
                end
            end
            RUN: begin
                if (mode == 2'b00) begin
                    // Stop wins over a tick due this cycle; frame is kept.
                    state_d = IDLE;
                    presc_d = '0;
                end else if (mode != mode_cur_q) begin
                    // Speed change restarts the interval and swallows any due tick.
                    mode_cur_d = mode;
                    presc_d    = period_m1(mode);
                end else if (presc_q == '0) begin
                    presc_d = period_m1(mode);
                    frame_d = frame_next(frame_q);
                    stb_d   = 1'b1;
                end else begin
                    presc_d = presc_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.frame_idx = frame_q;
    assign bus.frame_stb = stb_q;
    assign bus.running   = (state_q == RUN);
endmodule

// File: tb/tb_led_anim_ctrl.sv
`timescale 1ns/1ps
module tb_led_anim_ctrl;
    typedef struct {
        int c;
        int idx;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    ev_t  eo, ee;

    led_anim_ctrl_if bus();

    led_anim_ctrl #(
        .PERIOD_SLOW(10),
        .PERIOD_MED (5),
        .PERIOD_FAST(2),
        .CNT_W      (27),
        .NFRAMES    (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: logs (edge number, frame) for every strobe.
    always @(posedge clk) begin
        #1;
        if (bus.frame_stb === 1'b1) obs_q.push_back('{c: cyc, idx: int'(bus.frame_idx)});
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Reset for 2 cycles with switches at s; returns the edge at which RUN is entered.
    task automatic do_reset(input logic [1:0] s, output int e);
        rst = 1'b1;
        bus.sw = s;
        bus.btn_step = 1'b0;
        @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        e = cyc + 3;
    endtask

    task automatic test_reset;
        int r;
        rst = 1'b1;
        bus.sw = 2'b11;
        bus.btn_step = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.frame_idx !== 5'd0) begin failures++; $display("FAIL rst_frame_idx got=%0d exp=0", bus.frame_idx); end
        checks++;
        if (bus.frame_stb !== 1'b0) begin failures++; $display("FAIL rst_frame_stb got=%b exp=0", bus.frame_stb); end
        checks++;
        if (bus.running !== 1'b0) begin failures++; $display("FAIL rst_running got=%b exp=0", bus.running); end
        obs_q.delete();
        exp_q.delete();
        rst = 1'b0;
        r = cyc;
        wait_until(r + 2);
        checks++;
        if (bus.running !== 1'b0) begin failures++; $display("FAIL rst_running_early got=%b exp=0", bus.running); end
        wait_until(r + 3);
        checks++;
        if (bus.running !== 1'b1) begin failures++; $display("FAIL rst_running_entry got=%b exp=1", bus.running); end
        exp_q.push_back('{c: r + 5, idx: 1});
        exp_q.push_back('{c: r + 7, idx: 2});
        wait_until(r + 8);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL rst_strobe_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ee = exp_q.pop_front(); eo = obs_q.pop_front(); checks++;
            if (eo.c !== ee.c || eo.idx !== ee.idx) begin failures++; $display("FAIL rst_strobe got=(cyc %0d idx %0d) exp=(cyc %0d idx %0d)", eo.c, eo.idx, ee.c, ee.idx); end
        end
    endtask

    task automatic test_run_slow;
        int e;
        do_reset(2'b01, e);
        for (int k = 1; k <= 32; k++) exp_q.push_back('{c: e + 10 * k, idx: k % 32});
        wait_until(e + 322);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL slow_strobe_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ee = exp_q.pop_front(); eo = obs_q.pop_front(); checks++;
            if (eo.c !== ee.c || eo.idx !== ee.idx) begin failures++; $display("FAIL slow_strobe got=(cyc %0d idx %0d) exp=(cyc %0d idx %0d)", eo.c, eo.idx, ee.c, ee.idx); end
        end
    endtask

    task automatic test_speed_change;
        int e;
        do_reset(2'b01, e);
        // Change reaches the FSM at edge e+7, when the prescaler holds 3.
        wait_until(e + 4);
        bus.sw = 2'b10;
        for (int k = 1; k <= 3; k++) exp_q.push_back('{c: e + 7 + 5 * k, idx: k});
        wait_until(e + 24);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL speed_strobe_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ee = exp_q.pop_front(); eo = obs_q.pop_front(); checks++;
            if (eo.c !== ee.c || eo.idx !== ee.idx) begin failures++; $display("FAIL speed_strobe got=(cyc %0d idx %0d) exp=(cyc %0d idx %0d)", eo.c, eo.idx, ee.c, ee.idx); end
        end
    endtask

    task automatic test_stop_step;
        int e, t;
        do_reset(2'b11, e);
        for (int k = 1; k <= 7; k++) exp_q.push_back('{c: e + 2 * k, idx: k});
        // Stop reaches the FSM at edge e+16, the same edge a tick is due.
        wait_until(e + 13);
        bus.sw = 2'b00;
        wait_until(e + 16);
        checks++;
        if (bus.running !== 1'b0) begin failures++; $display("FAIL stop_running got=%b exp=0", bus.running); end
        checks++;
        if (bus.frame_idx !== 5'd7) begin failures++; $display("FAIL stop_frame_idx got=%0d exp=7", bus.frame_idx); end
        wait_until(e + 116);
        t = cyc;
        for (int p = 0; p < 3; p++) begin
            bus.btn_step = 1'b1;
            repeat (2) @(negedge clk);
            bus.btn_step = 1'b0;
            repeat (3) @(negedge clk);
            exp_q.push_back('{c: t + 3 + 5 * p, idx: 8 + p});
        end
        t = cyc;
        bus.btn_step = 1'b1;
        repeat (20) @(negedge clk);
        bus.btn_step = 1'b0;
        repeat (5) @(negedge clk);
        exp_q.push_back('{c: t + 3, idx: 11});
        checks++;
        if (bus.frame_idx !== 5'd11) begin failures++; $display("FAIL step_frame_idx got=%0d exp=11", bus.frame_idx); end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL step_strobe_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ee = exp_q.pop_front(); eo = obs_q.pop_front(); checks++;
            if (eo.c !== ee.c || eo.idx !== ee.idx) begin failures++; $display("FAIL step_strobe got=(cyc %0d idx %0d) exp=(cyc %0d idx %0d)", eo.c, eo.idx, ee.c, ee.idx); end
        end
    endtask

    task automatic test_step_in_run;
        int e;
        int pulses[3] = '{3, 17, 25};
        do_reset(2'b01, e);
        for (int k = 1; k <= 5; k++) exp_q.push_back('{c: e + 10 * k, idx: k});
        for (int p = 0; p < 3; p++) begin
            wait_until(e + pulses[p]);
            bus.btn_step = 1'b1;
            wait_until(e + pulses[p] + 2);
            bus.btn_step = 1'b0;
        end
        wait_until(e + 52);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL runstep_strobe_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ee = exp_q.pop_front(); eo = obs_q.pop_front(); checks++;
            if (eo.c !== ee.c || eo.idx !== ee.idx) begin failures++; $display("FAIL runstep_strobe got=(cyc %0d idx %0d) exp=(cyc %0d idx %0d)", eo.c, eo.idx, ee.c, ee.idx); end
        end
    endtask

    task automatic test_reset_mid_run;
        int e, e2;
        do_reset(2'b10, e);
        for (int k = 1; k <= 12; k++) exp_q.push_back('{c: e + 5 * k, idx: k});
        // After edge e+62 the prescaler holds 2 and frame_idx is 12.
        wait_until(e + 62);
        checks++;
        if (bus.frame_idx !== 5'd12) begin failures++; $display("FAIL midrst_pre_frame got=%0d exp=12", bus.frame_idx); end
        rst = 1'b1;
        wait_until(e + 63);
        checks++;
        if (bus.frame_idx !== 5'd0) begin failures++; $display("FAIL midrst_frame_idx got=%0d exp=0", bus.frame_idx); end
        checks++;
        if (bus.frame_stb !== 1'b0) begin failures++; $display("FAIL midrst_frame_stb got=%b exp=0", bus.frame_stb); end
        checks++;
        if (bus.running !== 1'b0) begin failures++; $display("FAIL midrst_running got=%b exp=0", bus.running); end
        rst = 1'b0;
        e2 = cyc + 3;
        exp_q.push_back('{c: e2 + 5, idx: 1});
        wait_until(e2 + 7);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL midrst_strobe_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ee = exp_q.pop_front(); eo = obs_q.pop_front(); checks++;
            if (eo.c !== ee.c || eo.idx !== ee.idx) begin failures++; $display("FAIL midrst_strobe got=(cyc %0d idx %0d) exp=(cyc %0d idx %0d)", eo.c, eo.idx, ee.c, ee.idx); end
        end
    endtask

    initial begin
        bus.sw = 2'b00;
        bus.btn_step = 1'b0;
        @(negedge clk);
        test_reset();
        test_run_slow();
        test_speed_change();
        test_stop_step();
        test_step_in_run();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_anim_ctrl.md
Name: led_anim_ctrl

Overview:
- Sequencer for the 16-LED animation datapath.
- Takes the two speed switches and a single-step button, and generates the frame-advance timing.
- Drives the 5-bit frame index into the frame ROM (next_frame), plus a one-cycle frame strobe.
- Replaces the loose switch / timer / frame-counter chain with one clocked, resettable controller. It runs on the board clock only and has no derived clocks.

Parameters:
- PERIOD_SLOW, 100000000, clocks per frame for sw=01 (1000 ms at 100 MHz).
- PERIOD_MED, 50000000, clocks per frame for sw=10 (500 ms).
- PERIOD_FAST, 20000000, clocks per frame for sw=11 (200 ms).
- CNT_W, 27, prescaler width. It must hold the largest PERIOD-1.
- NFRAMES, 32, frame count. frame_idx wraps from NFRAMES-1 to 0.

Ports:
- clk  in  1  board clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sw  in  2  speed switches, asynchronous. 00 = stop/step mode; 01/10/11 = slow/med/fast run.
- btn_step  in  1  step button, asynchronous, active-high. Assumed debounced externally.
- frame_idx  out  5  current frame number to the frame ROM.
- frame_stb  out  1  one-cycle pulse, high in the first cycle a new frame_idx is valid.
- running  out  1  high while in RUN state.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on any clk edge with rst=1, the following registers clear:
  - frame_idx=0, frame_stb=0, running=0
  - prescaler=0
  - sync registers and the btn edge register = 0
  - state=IDLE
- Reset mid-count aborts the interval. No strobe is emitted that cycle.

Input sync:
- sw and btn_step each pass through 2 flops: sw_s, btn_s.
- mode = sw_s. A switch change is visible to the FSM 2 clocks after the input changes.
- step_evt = btn_s & ~btn_s_d: one cycle per rising edge.

Period select:
- 01 → PERIOD_SLOW, 10 → PERIOD_MED, 11 → PERIOD_FAST.
- Each PERIOD must be ≥1. PERIOD=1 gives a tick every cycle.

FSM, 2 states:
- IDLE (mode==00):
  - running=0, prescaler held at 0.
  - step_evt → frame_idx advances by 1 (with wrap); frame_stb=1 next cycle.
  - mode!=00 → RUN; prescaler loaded with PERIOD(mode)-1.
- RUN (mode!=00):
  - running=1.
  - Each cycle: if prescaler==0, tick: reload PERIOD(mode)-1 and advance frame_idx; else decrement.
  - step_evt is ignored.
  - mode==00 → IDLE; prescaler cleared; frame_idx kept.
- Speed change within RUN (mode changes 01↔10↔11):
  - Prescaler reloads with the new PERIOD-1 in the cycle the change is seen.
  - Any tick due that cycle is suppressed (the change wins).
  - The first frame at the new speed comes exactly PERIOD(new) cycles later.
- Timing: the first advance after entering RUN occurs PERIOD clocks after the entry cycle. Advances then repeat every PERIOD clocks.

Outputs:
- frame_idx and frame_stb are registered together. frame_stb is high exactly in the cycle frame_idx first shows its new value; otherwise it is 0.
- Wrap: the frame after NFRAMES-1 is 0. No extra stall cycle.

Simultaneous events:
- rst overrides everything.
- A step_evt in the same cycle as an IDLE→RUN transition is dropped.
- A mode change to 00 in the same cycle as a tick: no advance.

Test Plan (PERIOD_SLOW=10, PERIOD_MED=5, PERIOD_FAST=2, NFRAMES=32):
1. Reset: hold rst 3 cycles with sw=11 → frame_idx=0, frame_stb=0, running=0. Release → running=1 at cycle 3 (2 sync + 1 FSM). First frame_stb 2 cycles after that, frame_idx=1.
2. Run slow: sw=01 steady → frame_stb period exactly 10 clocks. frame_idx 0→31 then wraps to 0 with strobe; 32 strobes in 320 clocks.
3. Speed change: sw=01, change to 10 midway through an interval at prescaler=3 → no strobe at the old due time. Next strobe exactly 5 clocks after the change is seen, then every 5.
4. Stop and step: sw 11→00 at frame_idx=7 → running=0, frame_idx stays 7, no strobes for 100 clocks. 3 btn_step pulses → frame_idx 8, 9, 10, each with a single frame_stb. Holding btn_step high 20 cycles gives only one advance.
5. Step ignored in RUN: sw=01, btn_step pulses → strobe spacing stays exactly 10, with no extra advances.
6. Reset mid-run: sw=10, assert rst at prescaler=2, frame_idx=12 → next cycle frame_idx=0, no strobe. After release, the first strobe comes 5 clocks after RUN re-entry.
